// File: rtl/biasreg_pkg.sv
// biasreg_pkg: shared constants and types for the ping-pong bias register file.
//   - bank ownership state encodings (EMPTY / LOAD / FULL)
//   - clog2_f helper used to size the bank index
//   - default width / latency constants
package biasreg_pkg;

  localparam logic [1:0] BANK_EMPTY = 2'd0;
  localparam logic [1:0] BANK_LOAD  = 2'd1;
  localparam logic [1:0] BANK_FULL  = 2'd2;

  typedef enum logic [1:0] {
    BS_EMPTY = BANK_EMPTY,
    BS_LOAD  = BANK_LOAD,
    BS_FULL  = BANK_FULL
  } bank_state_e;

  localparam int BR_BANK_NUM_DEF     = 2;
  localparam int BR_ADDR_WTH_DEF     = 9;
  localparam int BR_PROC_WTH_DEF     = 8;
  localparam int MR_PROC_H_PARAL_DEF = 8;
  localparam int MR_PROC_V_PARAL_DEF = 8;
  localparam int RD_LAT_DEF          = 3;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sdp_ram_bw.sv
// sdp_ram_bw: simple dual-port RAM, byte-enable write, 1-cycle registered read.
// Ports:
//   clk_i            clock
//   we_i/waddr_i     write enable / write address
//   wdata_i/wstrb_i  write data / per-byte enables
//   re_i/raddr_i     read enable / read address
//   rdata_o          registered read data (holds when re_i is low)
// A read and write to the same address in the same cycle returns old data.
module sdp_ram_bw #(
  parameter int DW = 512,
  parameter int AW = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   wstrb_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DW-1:0]     rdata_o
);

  localparam int DEPTH = 1 << AW;
  localparam int BW    = DW / 8;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BW; i++) begin
        if (wstrb_i[i]) mem[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/biasreg_pp.sv
// biasreg_pp: ping-pong bias register file. load_mtxreg_ctrl fills one bank
// while vputy reads another; a per-bank ownership FSM keeps reads and writes
// on disjoint banks.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ldmr_br__wbank/waddr/we/wdata/wstrb_i  write request (byte strobes)
//   ldmr_br__wdone_i              pulse: write bank fully loaded
//   ldmr_br__wrdy_o               per-bank writable (not FULL)
//   vputy_br__rbank/raddr/re_i    read request
//   vputy_br__rdone_i             pulse: read bank released
//   vputy_br__rrdy_o              per-bank readable (FULL)
//   vputy_br__rdata_o/rdata_act_o read data / valid strobe, RD_LAT after accept
//   br_err_clr_i                  clears sticky error flags
//   br_werr_o / br_rerr_o         sticky: write to FULL / read of non-FULL bank
//
// state    | meaning
// ---------+-----------------------------------------------
// BS_EMPTY | released, writable, nothing loaded yet
// BS_LOAD  | writer has started filling the bank
// BS_FULL  | loaded; readable, writes rejected until rdone
module biasreg_pp
  import biasreg_pkg::*;
#(
  parameter int BR_BANK_NUM     = BR_BANK_NUM_DEF,
  parameter int BR_BANK_WTH     = clog2_f(BR_BANK_NUM),
  parameter int BR_ADDR_WTH     = BR_ADDR_WTH_DEF,
  parameter int BR_PROC_WTH     = BR_PROC_WTH_DEF,
  parameter int MR_PROC_H_PARAL = MR_PROC_H_PARAL_DEF,
  parameter int MR_PROC_V_PARAL = MR_PROC_V_PARAL_DEF,
  parameter int MR_DATA_WTH     = BR_PROC_WTH * MR_PROC_V_PARAL * MR_PROC_H_PARAL,
  parameter int RD_LAT          = RD_LAT_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [BR_BANK_WTH-1:0]   ldmr_br__wbank_i,
  input  logic [BR_ADDR_WTH-1:0]   ldmr_br__waddr_i,
  input  logic                     ldmr_br__we_i,
  input  logic [MR_DATA_WTH-1:0]   ldmr_br__wdata_i,
  input  logic [MR_DATA_WTH/8-1:0] ldmr_br__wstrb_i,
  input  logic                     ldmr_br__wdone_i,
  output logic [BR_BANK_NUM-1:0]   ldmr_br__wrdy_o,
  input  logic [BR_BANK_WTH-1:0]   vputy_br__rbank_i,
  input  logic [BR_ADDR_WTH-1:0]   vputy_br__raddr_i,
  input  logic                     vputy_br__re_i,
  input  logic                     vputy_br__rdone_i,
  output logic [BR_BANK_NUM-1:0]   vputy_br__rrdy_o,
  output logic [MR_DATA_WTH-1:0]   vputy_br__rdata_o,
  output logic                     vputy_br__rdata_act_o,
  input  logic                     br_err_clr_i,
  output logic                     br_werr_o,
  output logic                     br_rerr_o
);

  localparam int PA_WTH = BR_BANK_WTH + BR_ADDR_WTH;
  localparam int PIPE_N = RD_LAT - 2;  // output register plus RD_LAT-3 extra stages

  bank_state_e bank_st_q [BR_BANK_NUM];
  bank_state_e bank_st_d [BR_BANK_NUM];

  logic [BR_BANK_NUM-1:0] wsel, rsel;
  logic wr_full, rd_full;
  logic we_acc, re_acc, werr_set, rerr_set;

  always_comb begin
    wsel = '0;
    rsel = '0;
    wsel[ldmr_br__wbank_i]  = 1'b1;
    rsel[vputy_br__rbank_i] = 1'b1;
  end

  assign wr_full  = (bank_st_q[ldmr_br__wbank_i] == BS_FULL);
  assign rd_full  = (bank_st_q[vputy_br__rbank_i] == BS_FULL);
  assign we_acc   = ldmr_br__we_i & ~wr_full;
  assign werr_set = ldmr_br__we_i & wr_full;
  assign re_acc   = vputy_br__re_i & rd_full;
  assign rerr_set = vputy_br__re_i & ~rd_full;

  // Bank ownership FSMs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < BR_BANK_NUM; b++) bank_st_q[b] <= BS_EMPTY;
    end else begin
      for (int b = 0; b < BR_BANK_NUM; b++) bank_st_q[b] <= bank_st_d[b];
    end
  end

  // wdone wins over we in EMPTY: the write still commits through the write
  // stage, the bank just skips LOAD.
  always_comb begin
    for (int b = 0; b < BR_BANK_NUM; b++) begin
      bank_st_d[b] = bank_st_q[b];
      case (bank_st_q[b])
        BS_EMPTY: begin
          if (ldmr_br__wdone_i && wsel[b])    bank_st_d[b] = BS_FULL;
          else if (ldmr_br__we_i && wsel[b])  bank_st_d[b] = BS_LOAD;
        end
        BS_LOAD: begin
          if (ldmr_br__wdone_i && wsel[b])    bank_st_d[b] = BS_FULL;
        end
        BS_FULL: begin
          if (vputy_br__rdone_i && rsel[b])   bank_st_d[b] = BS_EMPTY;
        end
        default:                              bank_st_d[b] = BS_EMPTY;
      endcase
    end
  end

  always_comb begin
    for (int b = 0; b < BR_BANK_NUM; b++) begin
      ldmr_br__wrdy_o[b]  = (bank_st_q[b] != BS_FULL);
      vputy_br__rrdy_o[b] = (bank_st_q[b] == BS_FULL);
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set
  logic werr_q, rerr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      werr_q <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      werr_q <= werr_set | (werr_q & ~br_err_clr_i);
      rerr_q <= rerr_set | (rerr_q & ~br_err_clr_i);
    end
  end

  assign br_werr_o = werr_q;
  assign br_rerr_o = rerr_q;

  // Write stage
  logic                     wr_v_q;
  logic [PA_WTH-1:0]        wr_addr_q;
  logic [MR_DATA_WTH-1:0]   wr_data_q;
  logic [MR_DATA_WTH/8-1:0] wr_strb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) wr_v_q <= 1'b0;
    else       wr_v_q <= we_acc;
  end

  always_ff @(posedge clk_i) begin
    wr_addr_q <= {ldmr_br__wbank_i, ldmr_br__waddr_i};
    wr_data_q <= ldmr_br__wdata_i;
    wr_strb_q <= ldmr_br__wstrb_i;
  end

  // Read stages: request register, RAM access, output pipe
  logic                   rd_v1_q, rd_v2_q;
  logic [PA_WTH-1:0]      rd_addr_q;
  logic [MR_DATA_WTH-1:0] ram_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_v1_q <= 1'b0;
      rd_v2_q <= 1'b0;
    end else begin
      rd_v1_q <= re_acc;
      rd_v2_q <= rd_v1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    rd_addr_q <= {vputy_br__rbank_i, vputy_br__raddr_i};
  end

  sdp_ram_bw #(
    .DW (MR_DATA_WTH),
    .AW (PA_WTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_v_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data_q),
    .wstrb_i (wr_strb_q),
    .re_i    (rd_v1_q),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  // Each data stage loads only when its upstream is valid, so the final
  // stage holds the last returned row between strobes.
  logic [PIPE_N-1:0]      pipe_v_q;
  logic [MR_DATA_WTH-1:0] pipe_d_q [PIPE_N];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_v_q <= '0;
      for (int i = 0; i < PIPE_N; i++) pipe_d_q[i] <= '0;
    end else begin
      pipe_v_q[0] <= rd_v2_q;
      if (rd_v2_q) pipe_d_q[0] <= ram_rdata;
      for (int i = 1; i < PIPE_N; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        if (pipe_v_q[i-1]) pipe_d_q[i] <= pipe_d_q[i-1];
      end
    end
  end

  assign vputy_br__rdata_o     = pipe_d_q[PIPE_N-1];
  assign vputy_br__rdata_act_o = pipe_v_q[PIPE_N-1];

endmodule

// File: tb/tb_biasreg_pp.sv
// tb_biasreg_pp: directed bench for biasreg_pp. Two instances share all
// inputs: u_dut3 (RD_LAT=3) and u_dut5 (RD_LAT=5).
module tb_biasreg_pp;

  localparam int DW = 512;
  localparam int SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wbank, rbank;
  logic [8:0]    waddr, raddr;
  logic          we, re, wdone, rdone, err_clr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;

  logic [1:0]    wrdy3, rrdy3, wrdy5, rrdy5;
  logic [DW-1:0] rdata3, rdata5;
  logic          act3, act5, werr3, werr5, rerr3, rerr5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  biasreg_pp #(.RD_LAT(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i),
    .ldmr_br__wbank_i(wbank), .ldmr_br__waddr_i(waddr), .ldmr_br__we_i(we),
    .ldmr_br__wdata_i(wdata), .ldmr_br__wstrb_i(wstrb), .ldmr_br__wdone_i(wdone),
    .ldmr_br__wrdy_o(wrdy3),
    .vputy_br__rbank_i(rbank), .vputy_br__raddr_i(raddr), .vputy_br__re_i(re),
    .vputy_br__rdone_i(rdone), .vputy_br__rrdy_o(rrdy3),
    .vputy_br__rdata_o(rdata3), .vputy_br__rdata_act_o(act3),
    .br_err_clr_i(err_clr), .br_werr_o(werr3), .br_rerr_o(rerr3)
  );

  biasreg_pp #(.RD_LAT(5)) u_dut5 (
    .clk_i(clk_i), .rst_i(rst_i),
    .ldmr_br__wbank_i(wbank), .ldmr_br__waddr_i(waddr), .ldmr_br__we_i(we),
    .ldmr_br__wdata_i(wdata), .ldmr_br__wstrb_i(wstrb), .ldmr_br__wdone_i(wdone),
    .ldmr_br__wrdy_o(wrdy5),
    .vputy_br__rbank_i(rbank), .vputy_br__raddr_i(raddr), .vputy_br__re_i(re),
    .vputy_br__rdone_i(rdone), .vputy_br__rrdy_o(rrdy5),
    .vputy_br__rdata_o(rdata5), .vputy_br__rdata_act_o(act5),
    .br_err_clr_i(err_clr), .br_werr_o(werr5), .br_rerr_o(rerr5)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; wdone = 1'b0; rdone = 1'b0; err_clr = 1'b0;
    wstrb = '1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; idle();
    wbank = 1'b0; rbank = 1'b0; waddr = '0; raddr = '0; wdata = '0;
    tick(); tick();
    rst_i = 1'b0;
    n_cmp++; if (wrdy3 !== 2'b11) begin n_err++; $display("FAIL rst_wrdy: got %b want 11", wrdy3); end
    n_cmp++; if (rrdy3 !== 2'b00) begin n_err++; $display("FAIL rst_rrdy: got %b want 00", rrdy3); end
    n_cmp++; if (rdata3 !== '0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rdata3); end
    n_cmp++; if (act3 !== 1'b0) begin n_err++; $display("FAIL rst_act: got %b want 0", act3); end
    n_cmp++; if ({werr3, rerr3} !== 2'b00) begin n_err++; $display("FAIL rst_err: got %b want 00", {werr3, rerr3}); end
    n_cmp++; if ({wrdy5, rrdy5, act5, werr5, rerr5} !== 7'b1100000) begin n_err++; $display("FAIL rst_dut5: got %b want 1100000", {wrdy5, rrdy5, act5, werr5, rerr5}); end
    n_cmp++; if (rdata5 !== '0) begin n_err++; $display("FAIL rst_rdata5: got %h want 0", rdata5); end
  endtask

  task automatic test_load_read();
    logic [7:0] bv;
    for (int r = 0; r < 4; r++) begin
      bv = 8'(r + 1);
      wbank = 1'b0; waddr = 9'(r); wdata = {64{bv}}; we = 1'b1;
      tick();
    end
    idle(); wdone = 1'b1; wbank = 1'b0;
    tick(); idle();
    n_cmp++; if (rrdy3 !== 2'b01) begin n_err++; $display("FAIL load_rrdy: got %b want 01", rrdy3); end
    n_cmp++; if (wrdy3 !== 2'b10) begin n_err++; $display("FAIL load_wrdy: got %b want 10", wrdy3); end
    re = 1'b1; rbank = 1'b0; raddr = 9'd2;
    tick(); idle(); tick();
    n_cmp++; if (act3 !== 1'b0) begin n_err++; $display("FAIL load_act_early: got %b want 0", act3); end
    tick();
    n_cmp++; if (act3 !== 1'b1) begin n_err++; $display("FAIL load_act: got %b want 1", act3); end
    n_cmp++; if (rdata3 !== {64{8'h03}}) begin n_err++; $display("FAIL load_rdata: got %h want %h", rdata3, {64{8'h03}}); end
    tick();
    n_cmp++; if (act3 !== 1'b0) begin n_err++; $display("FAIL load_act_pulse: got %b want 0", act3); end
    n_cmp++; if (rdata3 !== {64{8'h03}}) begin n_err++; $display("FAIL load_rdata_hold: got %h want %h", rdata3, {64{8'h03}}); end
  endtask

  task automatic test_ping_pong();
    logic [7:0]    bv;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 8) begin
        re = 1'b1; rbank = 1'b0; raddr = 9'(i % 4);
        bv = 8'hA0 + 8'(i);
        we = 1'b1; wbank = 1'b1; waddr = 9'(i); wdata = {64{bv}};
      end
      tick();
      if (i >= 2) begin
        bv = 8'(((i - 2) % 4) + 1);
        exp_d = {64{bv}};
        n_cmp++; if (act3 !== 1'b1) begin n_err++; $display("FAIL pp_act[%0d]: got %b want 1", i - 2, act3); end
        n_cmp++; if (rdata3 !== exp_d) begin n_err++; $display("FAIL pp_rdata[%0d]: got %h want %h", i - 2, rdata3, exp_d); end
      end
    end
    idle();
    rdone = 1'b1; rbank = 1'b0; wdone = 1'b1; wbank = 1'b1;
    tick(); idle();
    n_cmp++; if (rrdy3 !== 2'b10) begin n_err++; $display("FAIL pp_rrdy: got %b want 10", rrdy3); end
    n_cmp++; if (wrdy3 !== 2'b01) begin n_err++; $display("FAIL pp_wrdy: got %b want 01", wrdy3); end
    re = 1'b1; rbank = 1'b1; raddr = 9'd3;
    tick(); idle(); tick(); tick();
    n_cmp++; if (act3 !== 1'b1) begin n_err++; $display("FAIL pp_b1_act: got %b want 1", act3); end
    n_cmp++; if (rdata3 !== {64{8'hA3}}) begin n_err++; $display("FAIL pp_b1_rdata: got %h want %h", rdata3, {64{8'hA3}}); end
  endtask

  task automatic test_strobes();
    logic [DW-1:0] exp_d;
    exp_d = {{63{8'hFF}}, 8'h00};
    idle();
    we = 1'b1; wbank = 1'b0; waddr = 9'd5; wdata = {64{8'hFF}};
    tick();
    wdata = '0; wstrb = 64'h1; wdone = 1'b1;
    tick(); idle();
    n_cmp++; if (rrdy3 !== 2'b11) begin n_err++; $display("FAIL strb_rrdy: got %b want 11", rrdy3); end
    re = 1'b1; rbank = 1'b0; raddr = 9'd5;
    tick(); idle(); tick(); tick();
    n_cmp++; if (act3 !== 1'b1) begin n_err++; $display("FAIL strb_act: got %b want 1", act3); end
    n_cmp++; if (rdata3 !== exp_d) begin n_err++; $display("FAIL strb_rdata: got %h want %h", rdata3, exp_d); end
  endtask

  task automatic test_errors();
    logic [DW-1:0] exp_d;
    exp_d = {{63{8'hFF}}, 8'h00};
    idle();
    we = 1'b1; wbank = 1'b0; waddr = 9'd5; wdata = {64{8'h55}};
    tick(); idle();
    n_cmp++; if (werr3 !== 1'b1) begin n_err++; $display("FAIL werr_set: got %b want 1", werr3); end
    re = 1'b1; rbank = 1'b0; raddr = 9'd5;
    tick(); idle(); tick(); tick();
    n_cmp++; if (rdata3 !== exp_d) begin n_err++; $display("FAIL werr_row_kept: got %h want %h", rdata3, exp_d); end
    n_cmp++; if (werr3 !== 1'b1) begin n_err++; $display("FAIL werr_sticky: got %b want 1", werr3); end
    err_clr = 1'b1;
    tick(); idle();
    n_cmp++; if (werr3 !== 1'b0) begin n_err++; $display("FAIL werr_clr: got %b want 0", werr3); end
    rdone = 1'b1; rbank = 1'b1;
    tick(); idle();
    n_cmp++; if (rrdy3 !== 2'b01) begin n_err++; $display("FAIL rerr_rrdy: got %b want 01", rrdy3); end
    re = 1'b1; rbank = 1'b1; raddr = 9'd0;
    tick(); idle();
    n_cmp++; if (rerr3 !== 1'b1) begin n_err++; $display("FAIL rerr_set: got %b want 1", rerr3); end
    tick(); tick();
    n_cmp++; if (act3 !== 1'b0) begin n_err++; $display("FAIL rerr_no_act: got %b want 0", act3); end
    n_cmp++; if (rerr3 !== 1'b1) begin n_err++; $display("FAIL rerr_sticky: got %b want 1", rerr3); end
    err_clr = 1'b1; re = 1'b1; rbank = 1'b1;
    tick(); idle();
    n_cmp++; if (rerr3 !== 1'b1) begin n_err++; $display("FAIL rerr_clr_collide: got %b want 1", rerr3); end
    err_clr = 1'b1;
    tick(); idle();
    n_cmp++; if (rerr3 !== 1'b0) begin n_err++; $display("FAIL rerr_clr: got %b want 0", rerr3); end
  endtask

  task automatic test_reset_mid_read();
    idle();
    re = 1'b1; rbank = 1'b0; raddr = 9'd5;
    tick(); idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    n_cmp++; if (act3 !== 1'b0) begin n_err++; $display("FAIL mid_rst_act3: got %b want 0", act3); end
    n_cmp++; if ({wrdy3, rrdy3} !== 4'b1100) begin n_err++; $display("FAIL mid_rst_banks: got %b want 1100", {wrdy3, rrdy3}); end
    n_cmp++; if (rdata3 !== '0) begin n_err++; $display("FAIL mid_rst_rdata: got %h want 0", rdata3); end
    tick(); tick();
    n_cmp++; if (act5 !== 1'b0) begin n_err++; $display("FAIL mid_rst_act5: got %b want 0", act5); end
  endtask

  task automatic test_latency5();
    idle();
    we = 1'b1; wdone = 1'b1; wbank = 1'b0; waddr = 9'd7; wdata = {64{8'h77}};
    tick(); idle();
    re = 1'b1; rbank = 1'b0; raddr = 9'd7;
    tick(); idle(); tick(); tick();
    n_cmp++; if (act3 !== 1'b1) begin n_err++; $display("FAIL lat3_act: got %b want 1", act3); end
    n_cmp++; if (rdata3 !== {64{8'h77}}) begin n_err++; $display("FAIL lat3_rdata: got %h want %h", rdata3, {64{8'h77}}); end
    n_cmp++; if (act5 !== 1'b0) begin n_err++; $display("FAIL lat5_act_t3: got %b want 0", act5); end
    tick();
    n_cmp++; if (act5 !== 1'b0) begin n_err++; $display("FAIL lat5_act_t4: got %b want 0", act5); end
    tick();
    n_cmp++; if (act5 !== 1'b1) begin n_err++; $display("FAIL lat5_act_t5: got %b want 1", act5); end
    n_cmp++; if (rdata5 !== {64{8'h77}}) begin n_err++; $display("FAIL lat5_rdata: got %h want %h", rdata5, {64{8'h77}}); end
    tick();
    n_cmp++; if (act5 !== 1'b0) begin n_err++; $display("FAIL lat5_act_t6: got %b want 0", act5); end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_ping_pong();
    test_strobes();
    test_errors();
    test_reset_mid_read();
    test_latency5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
